// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply / divide unit for a pipelined core.
//   MUL, MADD and MSUB produce a 2*WIDTH product in one MUL-state cycle.
//   DIV is a restoring radix-2 divider on operand magnitudes that takes WIDTH cycles.
//   result_o is {HI,LO}. For DIV that is {remainder, quotient}.
//   Build option MULDIV_MADD_EN: when defined, MADD/MSUB add/subtract the product
//   to/from the captured acc_i. When undefined, the accumulator path is absent
//   and ops 2/3 behave as plain MUL.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 dbz_o
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [1:0] OP_DIV  = 2'd1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    // During DIV, a_mag_reg doubles as the dividend/quotient shift register.
    logic [WIDTH-1:0]  a_mag_reg;
    logic [WIDTH-1:0]  b_mag_reg;
    logic              a_neg_reg;
    logic              b_neg_reg;
    logic [WIDTH-1:0]  rem_reg;

    // Operand sign/magnitude at the start edge; unsigned operands are never negative.
    logic              a_neg_in;
    logic              b_neg_in;
    logic [WIDTH-1:0]  a_mag_in;
    logic [WIDTH-1:0]  b_mag_in;

    // Multiply datapath.
    logic [W2-1:0]     prod_mag;
    logic [W2-1:0]     prod_val;
    logic [W2-1:0]     mul_res;

    // Divide datapath (one restoring step per cycle).
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_trial;
    logic              div_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;
    logic [WIDTH-1:0]  rem_fix;
    logic [WIDTH-1:0]  quo_fix;

`ifdef MULDIV_MADD_EN
    localparam logic [1:0] OP_MADD = 2'd2;
    localparam logic [1:0] OP_MSUB = 2'd3;
    logic [1:0]        op_reg;
    logic [W2-1:0]     acc_reg;
`endif

    // Convert incoming operands to sign + magnitude (most-negative maps to 2^(WIDTH-1)).
    always_comb begin
        a_neg_in = signed_i & opa_i[WIDTH-1];
        b_neg_in = signed_i & opb_i[WIDTH-1];
        a_mag_in = a_neg_in ? (~opa_i + WIDTH'(1)) : opa_i;
        b_mag_in = b_neg_in ? (~opb_i + WIDTH'(1)) : opb_i;
    end

    // Unsigned magnitude product, negated when exactly one operand was negative.
    always_comb begin
        prod_mag = {{WIDTH{1'b0}}, a_mag_reg} * {{WIDTH{1'b0}}, b_mag_reg};
        prod_val = (a_neg_reg ^ b_neg_reg) ? (~prod_mag + W2'(1)) : prod_mag;
    end

`ifdef MULDIV_MADD_EN
    // Fold the captured accumulator into the product for MADD / MSUB.
    always_comb begin
        case (op_reg)
            OP_MADD: mul_res = acc_reg + prod_val;
            OP_MSUB: mul_res = acc_reg - prod_val;
            default: mul_res = prod_val;
        endcase
    end
`else
    // Without the accumulator path every multiply-class op returns the plain product.
    always_comb begin
        mul_res = prod_val;
    end

    logic unused_acc;
    assign unused_acc = ^acc_i;
`endif

    // One restoring-division step plus the final sign fix-up of quotient and remainder.
    always_comb begin
        rem_shift = {rem_reg, a_mag_reg[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, b_mag_reg};
        div_ge    = ~rem_trial[WIDTH];
        rem_next  = div_ge ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {a_mag_reg[WIDTH-2:0], div_ge};
        quo_fix   = (a_neg_reg ^ b_neg_reg) ? (~quo_next + WIDTH'(1)) : quo_next;
        rem_fix   = a_neg_reg ? (~rem_next + WIDTH'(1)) : rem_next;
    end

    // Control FSM with registered outputs; result_o/dbz_o only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_mag_reg <= '0;
            b_mag_reg <= '0;
            a_neg_reg <= 1'b0;
            b_neg_reg <= 1'b0;
            rem_reg   <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            dbz_o     <= 1'b0;
`ifdef MULDIV_MADD_EN
            op_reg    <= 2'd0;
            acc_reg   <= '0;
`endif
        end else begin
            ready_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        a_mag_reg <= a_mag_in;
                        b_mag_reg <= b_mag_in;
                        a_neg_reg <= a_neg_in;
                        b_neg_reg <= b_neg_in;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_o    <= 1'b1;
`ifdef MULDIV_MADD_EN
                        op_reg    <= op_i;
                        acc_reg   <= acc_i;
`endif
                        if (op_i == OP_DIV) begin
                            if (opb_i == '0) begin
                                // Divide by zero finishes immediately with a zero result.
                                state_reg <= DONE;
                                result_o  <= '0;
                                dbz_o     <= 1'b1;
                                ready_o   <= 1'b1;
                            end else begin
                                state_reg <= DIV;
                            end
                        end else begin
                            state_reg <= MUL;
                        end
                    end
                end

                MUL: begin
                    if (annul_i) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                    end else begin
                        state_reg <= DONE;
                        result_o  <= mul_res;
                        dbz_o     <= 1'b0;
                        ready_o   <= 1'b1;
                    end
                end

                DIV: begin
                    if (annul_i) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        a_mag_reg <= quo_next;
                        rem_reg   <= rem_next;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= DONE;
                            result_o  <= {rem_fix, quo_fix};
                            dbz_o     <= 1'b0;
                            ready_o   <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // ready_o was raised on entry; start_i is deliberately not looked at here.
                    state_reg <= IDLE;
                    busy_o    <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
